// File: rtl/ste_avg_iir_mc.sv
// Multi-channel first-order IIR averager, alpha = 2^-k, time-multiplexed one sample per cycle.
// Optional macro STE_AVG_ROUND_EN selects round-half-up with saturation on dout_o.
module ste_avg_iir_mc #(
  parameter int DATA_W = 16,
  parameter int CH_N   = 4,
  parameter int KMAX   = 8,
  localparam int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1,
  localparam int K_W   = $clog2(KMAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_i,
  input  logic [CH_W-1:0]   din_ch_i,
  input  logic              din_valid_i,
  input  logic [K_W-1:0]    avg_k_i,
  input  logic              avg_en_i,
  input  logic              avg_clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CH_W-1:0]   dout_ch_o,
  output logic              dout_update_o
);

  localparam int AW = DATA_W + KMAX;

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_din;
  logic [CH_W-1:0]   r_s1_ch;
  logic [K_W-1:0]    r_s1_k;
  logic              r_s1_en;

  logic [AW-1:0]     r_acc [CH_N];
  logic              r_seeded [CH_N];

  logic [DATA_W-1:0] r_dout;
  logic [CH_W-1:0]   r_dout_ch;
  logic              r_upd;

  logic              w_ch_ok;
  logic [K_W-1:0]    w_k_clamp;
  logic [AW-1:0]     w_acc_cur;
  logic              w_seed_cur;
  logic [AW-1:0]     w_x;
  logic signed [AW:0] w_diff;
  logic signed [AW:0] w_step;
  logic [AW-1:0]     w_sum;
  logic              w_load;
  logic [AW-1:0]     w_acc_new;
  logic [DATA_W-1:0] w_dout;

  assign w_ch_ok   = (32'(din_ch_i) < 32'(CH_N));
  assign w_k_clamp = (avg_k_i > K_W'(KMAX)) ? K_W'(KMAX) : avg_k_i;

  // Stage-1 read sees the previous edge's write, so back-to-back samples need no forwarding
  assign w_acc_cur  = r_acc[r_s1_ch];
  assign w_seed_cur = r_seeded[r_s1_ch];
  assign w_x        = AW'(r_s1_din) << KMAX;
  assign w_diff     = $signed({1'b0, w_x}) - $signed({1'b0, w_acc_cur});
  assign w_step     = w_diff >>> r_s1_k;
  assign w_sum      = w_acc_cur + AW'(w_step);
  assign w_load     = !w_seed_cur || !r_s1_en || (r_s1_k == '0);
  assign w_acc_new  = w_load ? w_x : w_sum;

`ifdef STE_AVG_ROUND_EN
  localparam logic [AW:0] ROUND_HALF = (KMAX > 0) ? (AW+1)'(1) << (KMAX - 1) : '0;
  logic [AW:0]       w_round;
  logic [DATA_W:0]   w_rq;
  assign w_round = {1'b0, w_acc_new} + ROUND_HALF;
  assign w_rq    = (DATA_W+1)'(w_round >> KMAX);
  assign w_dout  = w_rq[DATA_W] ? {DATA_W{1'b1}} : w_rq[DATA_W-1:0];
`else
  assign w_dout  = DATA_W'(w_acc_new >> KMAX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_din   <= '0;
      r_s1_ch    <= '0;
      r_s1_k     <= '0;
      r_s1_en    <= 1'b0;
      r_dout     <= '0;
      r_dout_ch  <= '0;
      r_upd      <= 1'b0;
      for (int i = 0; i < CH_N; i++) begin
        r_acc[i]    <= '0;
        r_seeded[i] <= 1'b0;
      end
    end else begin
      r_s1_valid <= din_valid_i && w_ch_ok;
      if (din_valid_i && w_ch_ok) begin
        r_s1_din <= din_i;
        r_s1_ch  <= din_ch_i;
        r_s1_k   <= w_k_clamp;
        r_s1_en  <= avg_en_i;
      end
      r_upd <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout    <= w_dout;
        r_dout_ch <= r_s1_ch;
      end
      // Clear wins over the completing sample's writeback; its output is still issued
      if (avg_clr_i) begin
        for (int i = 0; i < CH_N; i++) r_seeded[i] <= 1'b0;
      end else if (r_s1_valid) begin
        r_acc[r_s1_ch]    <= w_acc_new;
        r_seeded[r_s1_ch] <= 1'b1;
      end
    end
  end

  assign dout_o        = r_dout;
  assign dout_ch_o     = r_dout_ch;
  assign dout_update_o = r_upd;

endmodule

// File: tb/tb_ste_avg_iir_mc.sv
// Directed self-checking bench for ste_avg_iir_mc (DATA_W=16, CH_N=4, KMAX=8), plus a
// CH_N=5 instance used for the out-of-range channel drop.
module tb_ste_avg_iir_mc;

`ifdef STE_AVG_ROUND_EN
  localparam int EXP_SECOND = 1438;
`else
  localparam int EXP_SECOND = 1437;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [1:0]  din_ch;
  logic        din_valid;
  logic [3:0]  avg_k;
  logic        avg_en;
  logic        avg_clr;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_upd;

  logic [2:0]  din_ch5;
  logic        din_valid5;
  logic [15:0] dout5;
  logic [2:0]  dout_ch5;
  logic        dout_upd5;

  int n_vec = 0;
  int n_bad = 0;

  ste_avg_iir_mc #(.DATA_W(16), .CH_N(4), .KMAX(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din_i(din), .din_ch_i(din_ch), .din_valid_i(din_valid),
    .avg_k_i(avg_k), .avg_en_i(avg_en), .avg_clr_i(avg_clr),
    .dout_o(dout), .dout_ch_o(dout_ch), .dout_update_o(dout_upd)
  );

  ste_avg_iir_mc #(.DATA_W(16), .CH_N(5), .KMAX(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .din_i(din), .din_ch_i(din_ch5), .din_valid_i(din_valid5),
    .avg_k_i(avg_k), .avg_en_i(avg_en), .avg_clr_i(avg_clr),
    .dout_o(dout5), .dout_ch_o(dout_ch5), .dout_update_o(dout_upd5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One isolated sample; checks the 2-cycle latency and the result
  task automatic apply(input string tag, input logic [1:0] a_ch, input logic [15:0] a_din,
                       input logic [3:0] a_k, input logic a_en, input logic [15:0] a_exp);
    @(negedge clk);
    din = a_din; din_ch = a_ch; avg_k = a_k; avg_en = a_en; din_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ":early"}, 32'(dout_upd), 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, ":upd"}, 32'(dout_upd), 32'd1);
    check({tag, ":ch"}, 32'(dout_ch), 32'(a_ch));
    check({tag, ":dout"}, 32'(dout), 32'(a_exp));
  endtask

  // Back-to-back samples with k=2, en=1; output i is checked one edge after sample i+1 enters
  task automatic stream(input string tag, input int n, input logic [1:0] chs[4],
                        input logic [15:0] dins[4], input logic [15:0] exps[4]);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i < n) begin
        din = dins[i]; din_ch = chs[i]; avg_k = 4'd2; avg_en = 1'b1; din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        check({tag, ":first"}, 32'(dout_upd), 32'd0);
      end else begin
        check($sformatf("%s:upd%0d", tag, i - 1), 32'(dout_upd), 32'd1);
        check($sformatf("%s:ch%0d", tag, i - 1), 32'(dout_ch), 32'(chs[i-1]));
        check($sformatf("%s:dout%0d", tag, i - 1), 32'(dout), 32'(exps[i-1]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_ch = '0; din_valid = 1'b0; avg_k = '0; avg_en = 1'b0;
    avg_clr = 1'b0; din_ch5 = '0; din_valid5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:dout", 32'(dout), 32'd0);
    check("rst:ch", 32'(dout_ch), 32'd0);
    check("rst:upd", 32'(dout_upd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spaced sequence on ch0, then the same sequence back-to-back on unseeded ch2
    apply("seed", 2'd0, 16'd1000, 4'd2, 1'b1, 16'd1000);
    apply("avg1", 2'd0, 16'd2000, 4'd2, 1'b1, 16'd1250);
    apply("avg2", 2'd0, 16'd2000, 4'd2, 1'b1, 16'(EXP_SECOND));
    stream("b2b", 3, '{2'd2, 2'd2, 2'd2, 2'd0}, '{16'd1000, 16'd2000, 16'd2000, 16'd0},
           '{16'd1000, 16'd1250, 16'(EXP_SECOND), 16'd0});

    // ch0 acc = 368000: 2000 -> 368000 + 36000 = 404000 -> 1578
    stream("ilv", 4, '{2'd1, 2'd0, 2'd1, 2'd1}, '{16'd500, 16'd2000, 16'd500, 16'd500},
           '{16'd500, 16'd1578, 16'd500, 16'd500});

    // Clear between samples: 300 reseeds instead of averaging toward 825
    apply("ld1000", 2'd0, 16'd1000, 4'd2, 1'b0, 16'd1000);
    @(negedge clk); avg_clr = 1'b1;
    @(negedge clk); avg_clr = 1'b0;
    apply("clrseed", 2'd0, 16'd300, 4'd2, 1'b1, 16'd300);

    // Clear while a ch0 sample sits in stage 1: 300 -> 475 issued, writeback dropped
    @(negedge clk);
    din = 16'd1000; din_ch = 2'd0; avg_k = 4'd2; avg_en = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; avg_clr = 1'b1;
    @(posedge clk); #1;
    check("clrs1:upd", 32'(dout_upd), 32'd1);
    check("clrs1:dout", 32'(dout), 32'd475);
    @(negedge clk); avg_clr = 1'b0;
    apply("reseed", 2'd0, 16'd600, 4'd2, 1'b1, 16'd600);

    // Sample presented in the clear cycle is a seed
    @(negedge clk);
    din = 16'd900; din_ch = 2'd0; avg_k = 4'd2; avg_en = 1'b1; din_valid = 1'b1; avg_clr = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; avg_clr = 1'b0;
    @(posedge clk); #1;
    check("clrin:upd", 32'(dout_upd), 32'd1);
    check("clrin:dout", 32'(dout), 32'd900);

    // Pass-through, k=1, k=0 and clamped k=15 (777*256 + 65536>>8 -> 778; k=7 would give 779)
    apply("passthru", 2'd3, 16'd4000, 4'd2, 1'b0, 16'd4000);
    apply("k1", 2'd3, 16'd0, 4'd1, 1'b1, 16'd2000);
    apply("k0", 2'd3, 16'd777, 4'd0, 1'b1, 16'd777);
    apply("k15", 2'd3, 16'd1033, 4'd15, 1'b1, 16'd778);

    // Out-of-range channel on the CH_N=5 instance is dropped; an in-range one still works
    @(negedge clk);
    din = 16'd5000; din_ch5 = 3'd5; avg_k = 4'd2; avg_en = 1'b1; din_valid5 = 1'b1;
    @(negedge clk); din_valid5 = 1'b0;
    @(posedge clk); #1;
    check("drop:upd0", 32'(dout_upd5), 32'd0);
    @(posedge clk); #1;
    check("drop:upd1", 32'(dout_upd5), 32'd0);
    check("drop:dout", 32'(dout5), 32'd0);
    @(negedge clk);
    din = 16'd123; din_ch5 = 3'd4; din_valid5 = 1'b1;
    @(negedge clk); din_valid5 = 1'b0;
    @(posedge clk); #1;
    check("ch4:upd", 32'(dout_upd5), 32'd1);
    check("ch4:ch", 32'(dout_ch5), 32'd4);
    check("ch4:dout", 32'(dout5), 32'd123);

    // Asynchronous reset with a sample in flight
    @(negedge clk);
    din = 16'd50; din_ch = 2'd0; avg_k = 4'd2; avg_en = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst:dout", 32'(dout), 32'd0);
    check("mrst:upd", 32'(dout_upd), 32'd0);
    @(posedge clk); #1;
    check("mrst:hold", 32'(dout_upd), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst:lost", 32'(dout_upd), 32'd0);
    apply("postrst", 2'd0, 16'd3000, 4'd2, 1'b1, 16'd3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
